conv_acc_sched: RTL and testbench
=================================

Name: conv_acc_sched

Overview:
- Sequencing controller for the 3x3 convolution datapath.
- Gates window issue into the 9-input registered adder tree, which has fixed latency and no stall.
- Tracks valid tokens through the tree and accumulates tree sums across input channels into one output pixel.
- Buffers finished pixels in a small output FIFO with valid/ready handshake; upstream is throttled by credits, so the tree never produces a result with nowhere to go.

Parameters:
- WIDTH, 9, operand width; tree sums and accumulator are 2*WIDTH bits signed.
- TREE_LAT, 4, adder tree latency in cycles, input window to sum.
- OUT_DEPTH, 4, output FIFO depth in entries (power of two, >=2).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  start pulse; sampled only in IDLE.
- cfg_channels  in  8  input channels per output pixel; 0 treated as 1.
- cfg_pixels  in  16  output pixels per job; 0 treated as 1.
- win_valid  in  1  upstream window (9 products) presented to tree.
- win_ready  out  1  window accepted into tree this cycle when win_valid&&win_ready.
- tree_sum  in  2*WIDTH  signed adder tree output, TREE_LAT cycles after accept.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accept.
- out_data  out  2*WIDTH  signed accumulated pixel.
- out_last  out  1  head entry is final pixel of job.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse on DRAIN->IDLE.

Behaviour:
- Reset (async, any state): state=IDLE; all counters, accumulator, token pipe and FIFO cleared; win_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
- States:
  - IDLE: on cfg_start, latch ch=max(cfg_channels,1) and px=max(cfg_pixels,1), clear counters, go RUN.
  - RUN: accept windows. On the accept that completes px*ch windows, go DRAIN.
  - DRAIN: win_ready=0. When the token pipe is empty and the FIFO is empty, go IDLE and pulse done the same cycle.
- cfg_start outside IDLE is ignored. cfg inputs are not re-sampled mid-job.
- Token pipe: TREE_LAT-deep shift register carrying {valid, first_ch, last_ch, last_px}, advancing every cycle unconditionally.
  - first_ch: channel counter==0 at accept. last_ch: channel counter==ch-1. last_px: last_ch and pixel counter==px-1.
  - Channel counter wraps to 0 after ch-1; pixel counter increments on that wrap.
- Accumulate when the pipe output is valid: acc = first_ch ? tree_sum : acc+tree_sum.
  - If last_ch, push {acc_next, last_px} into the FIFO the same cycle; acc_next is the post-add value.
  - Arithmetic is signed 2*WIDTH. Without SAT_EN, the accumulator wraps modulo 2^(2*WIDTH).
- Credit rule: pend = number of valid pipe entries with last_ch set.
  - win_ready = (state==RUN) && (fifo_count + pend < OUT_DEPTH).
  - This guarantees no FIFO overflow. win_ready does not depend on win_valid.
- FIFO:
  - First-word-fall-through; out_data and out_last are registered from the head.
  - Push and pop in the same cycle with count>0: count unchanged.
  - Push while empty: out_valid rises the next cycle.
  - Pointers wrap modulo OUT_DEPTH.
- Latency: last window accepted at cycle t -> FIFO push at t+TREE_LAT -> out_valid at t+TREE_LAT+1 if the FIFO was empty.
- busy = (state!=IDLE).

Optional Feature:
- Macro: CONV_ACC_SAT_EN.
- Defined: the accumulator add saturates to [-2^(2W-1), 2^(2W-1)-1]. A sticky internal flag sets on any clamp and clears on cfg_start.
- Undefined: two's-complement wrap, no flag logic.
- The port list is identical in both builds.

Test Plan:
- Basic run: ch=3, px=2, tree_sum values 10,20,30 then -5,-5,-5 with out_ready=1 -> out_data 60 then -15; out_last only on -15; done one cycle after the FIFO drains.
- Back-pressure: ch=1, px=8, out_ready=0, win_valid=1 -> win_ready drops after exactly 4 accepts (OUT_DEPTH=4). With out_ready=1, all 8 pixels emerge in order with no loss.
- Zero config: cfg_channels=0, cfg_pixels=0 -> behaves as 1x1: one window yields one output equal to tree_sum, with out_last=1.
- Overflow (WIDTH=9): ch=2, tree_sum=131071 twice -> with CONV_ACC_SAT_EN out_data=131071; without it, out_data=-2.
- Restart guard: pulse cfg_start in RUN with different cfg -> ignored; job finishes with the original ch/px.
- Async reset: assert rst_n=0 mid-RUN with 2 tokens in flight -> all outputs 0 immediately. After release, no stale push; the next job's results are correct.

Source files
------------

// File: rtl/conv_acc_sched_if.sv
// Window/tree-sum and output-pixel handshake bundle for the conv_acc_sched sequencer.
// The master side is the upstream window source, adder tree and downstream sink.
interface conv_acc_sched_if #(
  parameter int WIDTH = 9
);
  logic                      win_valid;
  logic                      win_ready;
  logic signed [2*WIDTH-1:0] tree_sum;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [2*WIDTH-1:0] out_data;
  logic                      out_last;

  modport master (
    output win_valid, tree_sum, out_ready,
    input  win_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  win_valid, tree_sum, out_ready,
    output win_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/conv_acc_sched.sv
// Sequencer for the 3x3 convolution datapath: credit-gated window issue, token tracking
// through the fixed-latency adder tree, channel accumulation and an output FIFO.
// Build option CONV_ACC_SAT_EN selects a saturating accumulator with a sticky clamp flag.
module conv_acc_sched #(
  parameter int WIDTH     = 9,
  parameter int TREE_LAT  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [7:0]        cfg_channels,
  input  logic [15:0]       cfg_pixels,
  conv_acc_sched_if.slave   bus,
  output logic              busy,
  output logic              done
);
  localparam int DW = 2 * WIDTH;
  localparam int PW = $clog2(OUT_DEPTH);

  typedef logic signed [DW-1:0] data_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic valid;
    logic first_ch;
    logic last_ch;
    logic last_px;
  } token_t;

  state_t        state, state_n;
  logic [7:0]    ch_r, ch_cnt;
  logic [15:0]   px_r, px_cnt;
  token_t        pipe [TREE_LAT];
  token_t        tok_in, tok_out;
  data_t         acc, acc_next;
  data_t         mem_data [OUT_DEPTH];
  logic          mem_last [OUT_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic [PW:0]   count, count_left, count_n;
  data_t         head_data, out_data_r;
  logic          head_last, out_last_r, out_valid_r;
  logic          win_ready_c, accept, push, pop, start_ok, pipe_empty, drain_empty;
  int            pend;

  assign start_ok      = (state == IDLE) && cfg_start;
  assign accept        = bus.win_valid && win_ready_c;
  assign pop           = out_valid_r && bus.out_ready;
  assign tok_out       = pipe[TREE_LAT-1];
  assign push          = tok_out.valid && tok_out.last_ch;
  assign drain_empty   = pipe_empty && (count == '0);
  assign bus.win_ready = win_ready_c;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_last  = out_last_r;

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    tok_in          = '0;
    tok_in.valid    = accept;
    tok_in.first_ch = (ch_cnt == 8'd0);
    tok_in.last_ch  = (ch_cnt == ch_r - 8'd1);
    tok_in.last_px  = (ch_cnt == ch_r - 8'd1) && (px_cnt == px_r - 16'd1);
  end

  // Results already committed to the tree but not yet in the FIFO hold a credit each.
  always_comb begin
    pend       = 0;
    pipe_empty = 1'b1;
    for (int i = 0; i < TREE_LAT; i++) begin
      if (pipe[i].valid) begin
        pipe_empty = 1'b0;
        if (pipe[i].last_ch) pend++;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cfg_start) state_n = RUN;
      RUN:     if (accept && tok_in.last_px) state_n = DRAIN;
      DRAIN:   if (drain_empty) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    done        = (state == DRAIN) && drain_empty;
    win_ready_c = (state == RUN) && (int'(count) + pend < OUT_DEPTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_r   <= 8'd1;
      px_r   <= 16'd1;
      ch_cnt <= '0;
      px_cnt <= '0;
    end else if (start_ok) begin
      ch_r   <= (cfg_channels == 8'd0) ? 8'd1 : cfg_channels;
      px_r   <= (cfg_pixels == 16'd0) ? 16'd1 : cfg_pixels;
      ch_cnt <= '0;
      px_cnt <= '0;
    end else if (accept) begin
      if (tok_in.last_ch) begin
        ch_cnt <= '0;
        px_cnt <= px_cnt + 16'd1;
      end else begin
        ch_cnt <= ch_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TREE_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tok_in;
      for (int i = 1; i < TREE_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

`ifdef CONV_ACC_SAT_EN
  logic signed [DW:0] sum_wide;
  logic               clamp, sat_flag;

  // One guard bit exposes overflow; the top two bits disagree exactly when the add left range.
  always_comb begin
    sum_wide = (tok_out.first_ch ? '0 : {acc[DW-1], acc}) + {bus.tree_sum[DW-1], bus.tree_sum};
    clamp    = (sum_wide[DW] != sum_wide[DW-1]);
    acc_next = sum_wide[DW-1:0];
    if (clamp) acc_next = sum_wide[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      sat_flag <= 1'b0;
    else if (start_ok)               sat_flag <= 1'b0;
    else if (tok_out.valid && clamp) sat_flag <= 1'b1;
  end
`else
  always_comb begin
    acc_next = tok_out.first_ch ? bus.tree_sum : acc + bus.tree_sum;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             acc <= '0;
    else if (tok_out.valid) acc <= acc_next;
  end

  // NOTE: FIFO storage is not reset; the cleared pointers and count make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= acc_next;
      mem_last[wr_ptr] <= tok_out.last_px;
    end
  end

  // The registered head is loaded with whatever entry will sit at the read pointer next cycle.
  always_comb begin
    rd_ptr_n   = rd_ptr + PW'(pop);
    count_left = count - (PW+1)'(pop);
    count_n    = count_left + (PW+1)'(push);
    head_data  = '0;
    head_last  = 1'b0;
    if (count_left == '0) begin
      if (push) begin
        head_data = acc_next;
        head_last = tok_out.last_px;
      end
    end else begin
      head_data = mem_data[rd_ptr_n];
      head_last = mem_last[rd_ptr_n];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr      <= rd_ptr_n;
      count       <= count_n;
      out_valid_r <= (count_n != '0);
      out_data_r  <= head_data;
      out_last_r  <= head_last;
    end
  end
endmodule

// File: tb/tb_conv_acc_sched.sv
// Directed bench for conv_acc_sched: models the adder tree as a delay line and predicts
// every output pixel from the job configuration and the window sums fed in.
module tb_conv_acc_sched;
  localparam int WIDTH    = 9;
  localparam int DW       = 2 * WIDTH;
  localparam int TREE_LAT = 4;

  typedef struct {
    longint data;
    bit     last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic [7:0]  cfg_channels;
  logic [15:0] cfg_pixels;
  logic        busy, done;

  conv_acc_sched_if #(.WIDTH(WIDTH)) bus ();

  conv_acc_sched #(.WIDTH(WIDTH), .TREE_LAT(TREE_LAT), .OUT_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_channels(cfg_channels),
    .cfg_pixels(cfg_pixels), .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int     n_tests = 0, n_fail = 0;
  int     cyc = 0, n_acc = 0, done_cnt = 0, done_base = 0;
  int     last_acc_cyc = 0, first_valid_cyc = 0, last_pop_cyc = -100;
  bit     prev_valid = 1'b0;
  longint win_sum = 0;
  longint dl [TREE_LAT];
  longint sums_q [$];
  exp_t   exp_q [$];
  longint got_data [$];
  bit     got_last [$];

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint fit(input longint v);
    longint r;
`ifdef CONV_ACC_SAT_EN
    longint hi = (longint'(1) <<< (DW - 1)) - 1;
    r = (v > hi) ? hi : ((v < -hi - 1) ? -hi - 1 : v);
`else
    r = v & ((longint'(1) <<< DW) - 1);
    if (r >= (longint'(1) <<< (DW - 1))) r = r - (longint'(1) <<< DW);
`endif
    return r;
  endfunction

  // Expected pixels: sum each group of ch consecutive window sums, in arrival order.
  task automatic model_job(input int ch, input int px);
    longint a;
    exp_t   e;
    for (int p = 0; p < px; p++) begin
      a = 0;
      for (int c = 0; c < ch; c++) a = (c == 0) ? sums_q[p*ch+c] : fit(a + sums_q[p*ch+c]);
      e.data = a;
      e.last = (p == px - 1);
      exp_q.push_back(e);
    end
  endtask

  // External adder tree: a window's sum appears on tree_sum TREE_LAT cycles after accept.
  always @(posedge clk) begin
    bit     a;
    longint v;
    a = bus.win_valid && bus.win_ready;
    v = win_sum;
    if (a) begin
      n_acc++;
      last_acc_cyc = cyc;
    end
    #1;
    for (int i = TREE_LAT - 1; i > 0; i--) dl[i] = dl[i-1];
    dl[0] = a ? v : 0;
    bus.tree_sum = dl[TREE_LAT-1][DW-1:0];
  end

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.out_valid && !prev_valid) first_valid_cyc = cyc;
      prev_valid = bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
        got_data.push_back(longint'(bus.out_data));
        got_last.push_back(bus.out_last);
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", longint'(bus.out_data), e.data);
          check("out_last", longint'(bus.out_last), longint'(e.last));
        end
        if (bus.out_last) last_pop_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        check("done_timing", cyc, last_pop_cyc + 1);
      end
    end
  end

  task automatic start_job(input logic [7:0] c, input logic [15:0] p);
    got_data.delete();
    got_last.delete();
    done_base    = done_cnt;
    cfg_channels = c;
    cfg_pixels   = p;
    cfg_start    = 1'b1;
    step();
    cfg_start    = 1'b0;
  endtask

  task automatic feed_one(input longint s);
    int k = 0;
    bus.win_valid = 1'b1;
    win_sum       = s;
    while (!bus.win_ready && k < 300) begin
      step();
      k++;
    end
    if (k >= 300) check("win_ready_timeout", 0, 1);
    step();
    bus.win_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (done_cnt == done_base && k < 500) begin
      step();
      k++;
    end
    step();
    check("done_count", done_cnt - done_base, 1);
    check("busy_after_done", longint'(busy), 0);
    check("exp_drained", exp_q.size(), 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_win_ready"}, longint'(bus.win_ready), 0);
    check({tag, "_out_valid"}, longint'(bus.out_valid), 0);
    check({tag, "_out_data"},  longint'(bus.out_data), 0);
    check({tag, "_out_last"},  longint'(bus.out_last), 0);
    check({tag, "_busy"},      longint'(busy), 0);
    check({tag, "_done"},      longint'(done), 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < TREE_LAT; i++) dl[i] = 0;
    rst_n = 1'b0; cfg_start = 1'b0; cfg_channels = '0; cfg_pixels = '0;
    bus.win_valid = 1'b0; bus.out_ready = 1'b1; bus.tree_sum = '0;
    step(); step();
    check_quiet("reset");
    rst_n = 1'b1;
    step();

    // Basic run: 3 channels x 2 pixels.
    sums_q = '{10, 20, 30, -5, -5, -5};
    model_job(3, 2);
    start_job(8'd3, 16'd2);
    check("busy_run", longint'(busy), 1);
    foreach (sums_q[i]) feed_one(sums_q[i]);
    wait_done();
    check("basic_n", got_data.size(), 2);
    if (got_data.size() == 2) begin
      check("basic_px0", got_data[0], 60);
      check("basic_last0", longint'(got_last[0]), 0);
      check("basic_px1", got_data[1], -15);
      check("basic_last1", longint'(got_last[1]), 1);
    end

    // Back-pressure: with the sink stalled, credits allow exactly OUT_DEPTH accepts.
    sums_q = '{-20, -13, -6, 1, 8, 15, 22, 29};
    model_job(1, 8);
    bus.out_ready = 1'b0;
    start_job(8'd1, 16'd8);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      bus.win_valid = 1'b1;
      win_sum = sums_q[n];
      if (bus.win_ready) n++;
      step();
    end
    bus.win_valid = 1'b0;
    check("bp_accepts", n, 4);
    check("bp_out_valid", longint'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    for (int i = 4; i < 8; i++) feed_one(sums_q[i]);
    wait_done();
    check("bp_n", got_data.size(), 8);
    if (got_data.size() == 8) begin
      check("bp_px0", got_data[0], -20);
      check("bp_px7", got_data[7], 29);
      check("bp_last7", longint'(got_last[7]), 1);
    end

    // Zero config behaves as 1x1; also pins push-to-valid latency.
    sums_q = '{7};
    model_job(1, 1);
    start_job(8'd0, 16'd0);
    feed_one(7);
    wait_done();
    check("zero_n", got_data.size(), 1);
    if (got_data.size() == 1) begin
      check("zero_px", got_data[0], 7);
      check("zero_last", longint'(got_last[0]), 1);
    end
    check("latency", first_valid_cyc - last_acc_cyc, 5);

    // Accumulator overflow.
    sums_q = '{131071, 131071};
    model_job(2, 1);
    start_job(8'd2, 16'd1);
    foreach (sums_q[i]) feed_one(sums_q[i]);
    wait_done();
    if (got_data.size() == 1) begin
`ifdef CONV_ACC_SAT_EN
      check("ovf_px", got_data[0], 131071);
`else
      check("ovf_px", got_data[0], -2);
`endif
    end else check("ovf_n", got_data.size(), 1);

    // Restart guard: a mid-job start with a different config must be ignored.
    sums_q = '{1, 2, 3, 4};
    model_job(2, 2);
    start_job(8'd2, 16'd2);
    feed_one(1);
    cfg_channels = 8'd1; cfg_pixels = 16'd1; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int i = 1; i < 4; i++) feed_one(sums_q[i]);
    wait_done();
    check("guard_n", got_data.size(), 2);
    if (got_data.size() == 2) check("guard_px1", got_data[1], 7);

    // Async reset with two tokens in flight: outputs clear at once, nothing stale emerges.
    start_job(8'd1, 16'd4);
    feed_one(3);
    feed_one(4);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("async");
    step(); step();
    rst_n = 1'b1;
    repeat (10) step();
    check("async_no_stale", got_data.size(), 0);
    sums_q = '{5, -9};
    model_job(2, 1);
    start_job(8'd2, 16'd1);
    foreach (sums_q[i]) feed_one(sums_q[i]);
    wait_done();
    check("post_reset_n", got_data.size(), 1);
    if (got_data.size() == 1) check("post_reset_px", got_data[0], -4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
